// File: rtl/arbitro_round_robin_pkg.sv
// Shared constants and types for the round-robin VC scheduler.
//   NUM_VC  : number of input virtual-channel FIFOs
//   VC_W    : width of a VC index
//   QCNT_W  : width of the per-grant pop counter
//   state_e : scheduler state encoding
package arbitro_round_robin_pkg;

    localparam int unsigned NUM_VC = 4;
    localparam int unsigned VC_W   = 2;
    localparam int unsigned QCNT_W = 3;

    typedef logic [VC_W-1:0] vc_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

endpackage

// File: rtl/arbitro_round_robin_selector_rr.sv
// Combinational round-robin pick: first nonempty VC after rr_ptr, rr_ptr itself last.
//   rr_ptr    in  : search base (the search starts at rr_ptr+1)
//   nonempty  in  : bit i set when VCi has data
//   next_vc   out : selected VC (equals rr_ptr when nothing is valid)
//   any_valid out : at least one VC is nonempty
module arbitro_round_robin_selector_rr
    import arbitro_round_robin_pkg::*;
(
    input  vc_t               rr_ptr,
    input  logic [NUM_VC-1:0] nonempty,
    output vc_t               next_vc,
    output logic              any_valid
);

    vc_t cand;

    // Walk the ring starting one past the pointer; the k=NUM_VC step lands on rr_ptr itself.
    always_comb begin
        next_vc   = rr_ptr;
        any_valid = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_VC; k++) begin
            cand = VC_W'(32'(rr_ptr) + k);
            if (!any_valid && nonempty[cand]) begin
                next_vc   = cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_round_robin.sv
// Work-conserving round-robin scheduler draining four VC FIFOs into one egress FIFO.
// Each grant serves one VC for at most QUANTUM pops; popped words reach the egress
// two cycles later through a non-stalling two-stage pipe.
//   clk, reset_L    : clock, asynchronous active-low reset
//   fifo_empty      : per-VC empty flags (registered in the FIFOs)
//   fifo_data       : per-VC read data, VCi at [i*DATA_W +: DATA_W], valid cycle after pop
//   out_almost_full : egress nearly full; freezes the scheduler
//   pop             : one-hot pop to the selected VC FIFO (combinational)
//   push, data_out  : egress write strobe and word
//   active_vc, idle : currently granted VC, scheduler idle flag
module arbitro_round_robin
    import arbitro_round_robin_pkg::*;
#(
    parameter int unsigned DATA_W  = 6,
    parameter int unsigned QUANTUM = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [NUM_VC-1:0]        fifo_empty,
    input  logic [NUM_VC*DATA_W-1:0] fifo_data,
    input  logic                     out_almost_full,
    output logic [NUM_VC-1:0]        pop,
    output logic                     push,
    output logic [DATA_W-1:0]        data_out,
    output logic [VC_W-1:0]          active_vc,
    output logic                     idle
);

    localparam logic [QCNT_W-1:0] QLAST = QCNT_W'(QUANTUM - 1);

    state_e            state_q, state_d;
    vc_t               cur_q, cur_d;
    vc_t               rr_ptr_q, rr_ptr_d;
    logic [QCNT_W-1:0] qcnt_q, qcnt_d;
    logic              v1_q, v1_d;
    vc_t               vc_d1_q, vc_d1_d;
    logic              push_q, push_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    vc_t               sel_base;
    vc_t               next_vc;
    logic              any_valid;
    logic              pop_en;
    logic [DATA_W-1:0] rd_word [NUM_VC];

    // While serving, search relative to the current VC so it becomes the last candidate.
    assign sel_base = (state_q == ST_SERVE) ? cur_q : rr_ptr_q;

    arbitro_round_robin_selector_rr u_sel (
        .rr_ptr    (sel_base),
        .nonempty  (~fifo_empty),
        .next_vc   (next_vc),
        .any_valid (any_valid)
    );

    for (genvar g = 0; g < NUM_VC; g++) begin : g_unpack
        assign rd_word[g] = fifo_data[g*DATA_W +: DATA_W];
    end

    // Scheduler next-state: grant, quantum counting, re-search on empty or quantum end.
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        rr_ptr_d = rr_ptr_q;
        qcnt_d   = qcnt_q;
        pop_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_valid && !out_almost_full) begin
                    state_d = ST_SERVE;
                    cur_d   = next_vc;
                    qcnt_d  = '0;
                end
            end
            ST_SERVE: begin
                if (!out_almost_full) begin
                    if (!fifo_empty[cur_q]) begin
                        pop_en = 1'b1;
                        if (qcnt_q < QLAST) begin
                            qcnt_d = qcnt_q + QCNT_W'(1);
                        end else begin
                            // cur is nonempty here, so the search always succeeds and
                            // falls back to regranting cur when no other VC has data.
                            rr_ptr_d = cur_q;
                            cur_d    = next_vc;
                            qcnt_d   = '0;
                        end
                    end else begin
                        rr_ptr_d = cur_q;
                        if (any_valid) begin
                            cur_d  = next_vc;
                            qcnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One-hot pop decode.
    always_comb begin
        pop = '0;
        if (pop_en) begin
            pop[cur_q] = 1'b1;
        end
    end

    // Data pipe: stage 1 remembers which VC was popped, stage 2 captures its word.
    always_comb begin
        v1_d       = pop_en;
        vc_d1_d    = pop_en ? cur_q : vc_d1_q;
        push_d     = v1_q;
        data_out_d = v1_q ? rd_word[vc_d1_q] : data_out_q;
    end

    // Scheduler registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            rr_ptr_q <= VC_W'(NUM_VC - 1);
            qcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            rr_ptr_q <= rr_ptr_d;
            qcnt_q   <= qcnt_d;
        end
    end

    // Pipe registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            v1_q       <= 1'b0;
            vc_d1_q    <= '0;
            push_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            v1_q       <= v1_d;
            vc_d1_q    <= vc_d1_d;
            push_q     <= push_d;
            data_out_q <= data_out_d;
        end
    end

    assign push      = push_q;
    assign data_out  = data_out_q;
    assign active_vc = cur_q;
    assign idle      = (state_q == ST_IDLE);

endmodule
